// File: rtl/pipelined_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_adder_pkg
//   Shared defaults and a small helper for the pipelined add/subtract unit.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default parameter values for the top.
//   signedOverflow()               : two's-complement overflow from the MSBs
//                                    of both addends and of the result.
// ---------------------------------------------------------------------------
package pipelined_adder_pkg;

   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_STAGES = 4;

   // Overflow happens only when both addends share a sign and the result's
   // sign differs from it. The second addend is the already-inverted operand
   // in subtract mode, so this single rule covers add and subtract.
   function automatic logic signedOverflow(input logic aMsb,
                                           input logic bMsb,
                                           input logic sMsb);
      return (aMsb == bMsb) && (sMsb != aMsb);
   endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
//   Purely combinational CHUNK-bit full adder: {co, r} = x + y + ci.
//   One slice sits in each pipeline stage of pipelined_adder.
//   Ports:
//     x, y  in  CHUNK  addend chunks
//     ci    in  1      carry in from the previous stage
//     r     out CHUNK  sum chunk
//     co    out 1      carry out to the next stage
// ---------------------------------------------------------------------------
module adder_slice
   import pipelined_adder_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] r,
   output logic             co
);

   // Operands are zero-extended by one bit so the top bit of the sum is the carry.
   assign {co, r} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit two's-complement add/subtract unit whose carry chain is split
//   into STAGES register stages of CHUNK = WIDTH/STAGES bits each. Stage k
//   adds chunk k using the carry registered by stage k-1. Upper operand chunks
//   travel alongside (skew) and finished lower result chunks travel forward
//   (deskew), so the full sum leaves the last stage aligned.
//   Flow control is a single global advance: every stage moves together when
//   the output is empty or being consumed; bubbles are carried, not collapsed.
//   Ports:
//     clk        in   1      clock, rising edge
//     rst_n      in   1      asynchronous active-low reset
//     in_valid   in   1      a/b/cin/sub valid
//     in_ready   out  1      an operand set is accepted this cycle
//     a, b       in   WIDTH  operands
//     cin        in   1      carry-in (add) / borrow-in (sub)
//     sub        in   1      0: s=a+b+cin  1: s=a-b-cin
//     out_valid  out  1      s/cout/ovf valid
//     out_ready  in   1      downstream consumes the result
//     s          out  WIDTH  result modulo 2^WIDTH
//     cout       out  1      carry out of the MSB (sub: 1 = no borrow)
//     ovf        out  1      signed overflow
// ---------------------------------------------------------------------------
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : gBadParam
      $error("pipelined_adder: WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
             WIDTH, STAGES);
   end

   logic             adv;
   logic [WIDTH-1:0] bx;
   logic             c0;

   // Per-stage pipeline state: valid bit, carry into the next stage, the
   // operands carried along, and the partially assembled result.
   logic             valid_q [STAGES];
   logic             valid_d [STAGES];
   logic             carry_q [STAGES];
   logic             carry_d [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] bx_q    [STAGES];
   logic [WIDTH-1:0] bx_d    [STAGES];
   logic [WIDTH-1:0] res_q   [STAGES];
   logic [WIDTH-1:0] res_d   [STAGES];

   // Whole pipeline advances unless a finished result is stuck at the output.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Subtraction is a + ~b + 1; the borrow-in inverts into the carry-in.
   assign bx = sub ? ~b : b;
   assign c0 = sub ? ~cin : cin;

   for (genvar k = 0; k < STAGES; k++) begin : gStage
      logic [WIDTH-1:0] stageX;
      logic [WIDTH-1:0] stageY;
      logic [WIDTH-1:0] stageRes;
      logic             stageC;
      logic             stageValid;
      logic [WIDTH-1:0] merged;
      logic [CHUNK-1:0] sliceR;
      logic             sliceCo;

      if (k == 0) begin : gFirst
         assign stageX     = a;
         assign stageY     = bx;
         assign stageC     = c0;
         assign stageRes   = '0;
         assign stageValid = in_valid;
      end else begin : gRest
         assign stageX     = a_q[k-1];
         assign stageY     = bx_q[k-1];
         assign stageC     = carry_q[k-1];
         assign stageRes   = res_q[k-1];
         assign stageValid = valid_q[k-1];
      end

      adder_slice #(.CHUNK(CHUNK)) uSlice (
         .x  (stageX[k*CHUNK +: CHUNK]),
         .y  (stageY[k*CHUNK +: CHUNK]),
         .ci (stageC),
         .r  (sliceR),
         .co (sliceCo)
      );

      // Drop this stage's freshly computed chunk into the travelling result.
      always_comb begin
         merged                     = stageRes;
         merged[k*CHUNK +: CHUNK]   = sliceR;
      end

      assign valid_d[k] = stageValid;
      assign carry_d[k] = sliceCo;
      assign a_d[k]     = stageX;
      assign bx_d[k]    = stageY;
      assign res_d[k]   = merged;
   end

   // All stage registers share one enable so bubbles and stalls keep their
   // positions; reset clears every valid bit, flushing anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            carry_q[k] <= 1'b0;
            a_q[k]     <= '0;
            bx_q[k]    <= '0;
            res_q[k]   <= '0;
         end
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            carry_q[k] <= carry_d[k];
            a_q[k]     <= a_d[k];
            bx_q[k]    <= bx_d[k];
            res_q[k]   <= res_d[k];
         end
      end
   end

   assign out_valid = valid_q[LAST];
   assign s         = res_q[LAST];
   assign cout      = carry_q[LAST];
   assign ovf       = signedOverflow(a_q[LAST][WIDTH-1], bx_q[LAST][WIDTH-1],
                                     res_q[LAST][WIDTH-1]);

endmodule
